branch_predictor_bht: RTL

- Parametrised branch-decision block for the pipelined core; successor to the fixed branch-condition decode.
- Resolves branch taken/not-taken for all six RV32I branch types from funct3 plus comparator flags.
- Holds a direct-mapped branch history table (BHT) of 2-bit saturating counters that predicts taken/not-taken at fetch.
- Reports mispredicts to the hazard unit and keeps a saturating mispredict count.

---
 rtl/branch_pkg.sv | 26 ++
 rtl/branch_cond_dec.sv | 27 ++
 rtl/branch_predictor_bht.sv | 86 ++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared branch types: funct3 codes, BHT counter type and counter constants.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_RESET     = 2'b01;
  localparam bht_ctr_t BHT_STRONG_T  = 2'b11;
  localparam bht_ctr_t BHT_STRONG_NT = 2'b00;

  function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
    if (taken)
      return (ctr == BHT_STRONG_T) ? ctr : bht_ctr_t'(ctr + 2'd1);
    else
      return (ctr == BHT_STRONG_NT) ? ctr : bht_ctr_t'(ctr - 2'd1);
  endfunction

endpackage

// File: rtl/branch_cond_dec.sv
// Combinational RV32I branch condition decode: funct3 + comparator flags -> taken/illegal.
module branch_cond_dec
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       eq,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      BEQ:     taken = eq;
      BNE:     taken = !eq;
      BLT:     taken = lt;
      BGE:     taken = !lt;
      BLTU:    taken = ltu;
      BGEU:    taken = !ltu;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped 2-bit BHT predictor with branch resolve and mispredict statistics.
// Define BHT_BYPASS_EN to forward a same-cycle, same-index update to the predict read.
module branch_predictor_bht
  import branch_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IDX_BITS = 5,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid_i,
  input  logic [XLEN-1:0]  pred_pc_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  input  logic             res_valid_i,
  input  logic [XLEN-1:0]  res_pc_i,
  input  logic [2:0]       res_funct3_i,
  input  logic             res_eq_i,
  input  logic             res_lt_i,
  input  logic             res_ltu_i,
  input  logic             res_pred_i,
  output logic             res_taken_o,
  output logic             mispredict_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int unsigned DEPTH = 2**IDX_BITS;

  bht_ctr_t bht [DEPTH];

  logic [IDX_BITS-1:0] pred_idx, res_idx;
  logic                dec_taken, dec_illegal, res_update, res_miss;
  bht_ctr_t            res_ctr_nxt, pred_ctr;
  logic                unused_pc;

  assign pred_idx  = pred_pc_i[IDX_BITS+1:2];
  assign res_idx   = res_pc_i[IDX_BITS+1:2];
  assign unused_pc = ^{pred_pc_i[XLEN-1:IDX_BITS+2], pred_pc_i[1:0],
                       res_pc_i[XLEN-1:IDX_BITS+2], res_pc_i[1:0]};

  branch_cond_dec u_dec (
    .funct3  (res_funct3_i),
    .eq      (res_eq_i),
    .lt      (res_lt_i),
    .ltu     (res_ltu_i),
    .taken   (dec_taken),
    .illegal (dec_illegal)
  );

  assign res_update  = res_valid_i && !dec_illegal;
  assign res_miss    = dec_taken != res_pred_i;
  assign res_ctr_nxt = bht_next(bht[res_idx], dec_taken);

`ifdef BHT_BYPASS_EN
  assign pred_ctr = (res_update && (pred_idx == res_idx)) ? res_ctr_nxt : bht[pred_idx];
`else
  assign pred_ctr = bht[pred_idx];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) bht[i] <= BHT_RESET;
      pred_valid_o  <= 1'b0;
      pred_taken_o  <= 1'b0;
      res_taken_o   <= 1'b0;
      mispredict_o  <= 1'b0;
      illegal_o     <= 1'b0;
      mispred_cnt_o <= '0;
    end else begin
      pred_valid_o <= pred_valid_i;
      if (pred_valid_i) pred_taken_o <= pred_ctr[1];
      mispredict_o <= 1'b0;
      illegal_o    <= res_valid_i && dec_illegal;
      if (res_update) begin
        bht[res_idx] <= res_ctr_nxt;
        res_taken_o  <= dec_taken;
        mispredict_o <= res_miss;
        if (res_miss && (mispred_cnt_o != '1))
          mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule
